// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: decode-stage controller that expands IITB-RISC load-multiple
// (LM) and store-multiple (SM) instructions into one micro-op per register.
// All other instructions pass through as a single micro-op. Fetch is stalled
// through in_ready while a multi-register sequence is in progress.
module lmsm_sequencer #(
  parameter logic [3:0] OPC_LM = 4'b0110,
  parameter logic [3:0] OPC_SM = 4'b0111
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  output logic        uop_valid,
  input  logic        uop_ready,
  output logic [15:0] uop_instr,
  output logic [1:0]  uop_mode,
  output logic [2:0]  uop_reg,
  output logic [2:0]  uop_base,
  output logic [2:0]  uop_offset,
  output logic        uop_last
);

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_LM   = 2'b01,
    MODE_SM   = 2'b10
  } mode_e;

  // Index of the lowest set bit; the caller guarantees v != 0.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  // The instruction encodes R0 in bit 7 and R7 in bit 0; flip it so that bit
  // n of the internal list stands for register Rn.
  function automatic logic [7:0] to_reg_order(input logic [7:0] field);
    for (int r = 0; r < 8; r++) begin
      to_reg_order[r] = field[7-r];
    end
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  remain_q, remain_d;   // registers still to transfer, bit n = Rn
  logic [2:0]  cnt_q, cnt_d;         // word offset of the next transfer

  logic        uop_valid_d;
  logic [15:0] uop_instr_d;
  logic [1:0]  uop_mode_d;
  logic [2:0]  uop_reg_d;
  logic [2:0]  uop_base_d;
  logic [2:0]  uop_offset_d;
  logic        uop_last_d;

  logic        adv;
  logic        accept;
  logic        is_lm;
  logic        is_sm;
  logic [7:0]  in_list;
  logic [2:0]  in_first;
  logic [7:0]  in_rest;
  logic [2:0]  seq_reg;
  logic [7:0]  seq_rest;

  // Handshake and decode of the incoming word and of the pending list.
  always_comb begin
    adv      = !uop_valid || uop_ready;
    in_ready = resetn && (state_q == IDLE) && adv && !flush;
    accept   = in_valid && in_ready;
    is_lm    = (in_instr[15:12] == OPC_LM);
    is_sm    = (in_instr[15:12] == OPC_SM);
    in_list  = to_reg_order(in_instr[7:0]);
    in_first = lowest_set(in_list);
    in_rest  = in_list & ~(8'd1 << in_first);
    seq_reg  = lowest_set(remain_q);
    seq_rest = remain_q & ~(8'd1 << seq_reg);
  end

  // Next-state and next micro-op selection.
  always_comb begin
    // NOTE: every target gets a hold default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    remain_d     = remain_q;
    cnt_d        = cnt_q;
    uop_valid_d  = uop_valid;
    uop_instr_d  = uop_instr;
    uop_mode_d   = uop_mode;
    uop_reg_d    = uop_reg;
    uop_base_d   = uop_base;
    uop_offset_d = uop_offset;
    uop_last_d   = uop_last;

    if (flush) begin
      // Redirect: drop any held micro-op and abandon the sequence.
      state_d     = IDLE;
      remain_d    = 8'd0;
      cnt_d       = 3'd0;
      uop_valid_d = 1'b0;
    end else if (adv) begin
      if (state_q == SEQ) begin
        uop_valid_d  = 1'b1;
        uop_reg_d    = seq_reg;
        uop_offset_d = cnt_q;
        remain_d     = seq_rest;
        cnt_d        = cnt_q + 3'd1;
        uop_last_d   = (seq_rest == 8'd0);
        if (seq_rest == 8'd0) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      end else if (accept) begin
        uop_valid_d = 1'b1;
        uop_instr_d = in_instr;
        if ((is_lm || is_sm) && (in_list != 8'd0)) begin
          uop_mode_d   = is_lm ? MODE_LM : MODE_SM;
          uop_reg_d    = in_first;
          uop_base_d   = in_instr[11:9];
          uop_offset_d = 3'd0;
          remain_d     = in_rest;
          uop_last_d   = (in_rest == 8'd0);
          if (in_rest == 8'd0) begin
            cnt_d = 3'd0;
          end else begin
            cnt_d   = 3'd1;
            state_d = SEQ;
          end
        end else begin
          uop_mode_d   = MODE_PASS;
          uop_reg_d    = 3'd0;
          uop_base_d   = 3'd0;
          uop_offset_d = 3'd0;
          uop_last_d   = 1'b1;
          remain_d     = 8'd0;
          cnt_d        = 3'd0;
        end
      end else begin
        uop_valid_d = 1'b0;
      end
    end
  end

  // State and output registers; reset abandons any sequence immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      remain_q   <= 8'd0;
      cnt_q      <= 3'd0;
      uop_valid  <= 1'b0;
      uop_instr  <= 16'd0;
      uop_mode   <= 2'b00;
      uop_reg    <= 3'd0;
      uop_base   <= 3'd0;
      uop_offset <= 3'd0;
      uop_last   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q    <= state_d;
      remain_q   <= remain_d;
      cnt_q      <= cnt_d;
      uop_valid  <= uop_valid_d;
      uop_instr  <= uop_instr_d;
      uop_mode   <= uop_mode_d;
      uop_reg    <= uop_reg_d;
      uop_base   <= uop_base_d;
      uop_offset <= uop_offset_d;
      uop_last   <= uop_last_d;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: table-driven vectors plus hand-written corner sequences.
// Expected micro-ops are pushed to a scoreboard queue when an instruction is
// accepted and popped/compared when the DUT hands a micro-op off.
module tb_lmsm_sequencer;

  typedef struct packed {
    logic [15:0] instr;
    logic [1:0]  mode;
    logic [2:0]  rg;
    logic [2:0]  base;
    logic [2:0]  off;
    logic        last;
  } uop_t;

  typedef struct {
    logic [15:0] instr;
    int          n_uops;
    logic [1:0]  mode;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'd0;
  logic        in_ready;
  logic        uop_valid;
  logic        uop_ready = 1'b0;
  logic [15:0] uop_instr;
  logic [1:0]  uop_mode;
  logic [2:0]  uop_reg;
  logic [2:0]  uop_base;
  logic [2:0]  uop_offset;
  logic        uop_last;

  int   n_vec = 0;
  int   n_err = 0;
  int   handoffs = 0;
  logic [1:0] last_mode = 2'b00;
  uop_t sb_q[$];

  always #5 clk = ~clk;

  lmsm_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .uop_valid  (uop_valid),
    .uop_ready  (uop_ready),
    .uop_instr  (uop_instr),
    .uop_mode   (uop_mode),
    .uop_reg    (uop_reg),
    .uop_base   (uop_base),
    .uop_offset (uop_offset),
    .uop_last   (uop_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference expansion: walk R0..R7, pick the registers whose list bit is set.
  task automatic push_model(input logic [15:0] ins);
    uop_t u;
    int   n;
    int   k;
    logic [3:0] opc;
    opc = ins[15:12];
    n   = $countones(ins[7:0]);
    if ((opc == 4'b0110 || opc == 4'b0111) && n != 0) begin
      k = 0;
      for (int r = 0; r < 8; r++) begin
        if (ins[7-r]) begin
          u.instr = ins;
          u.mode  = (opc == 4'b0110) ? 2'b01 : 2'b10;
          u.rg    = 3'(r);
          u.base  = ins[11:9];
          u.off   = 3'(k);
          k++;
          u.last  = (k == n);
          sb_q.push_back(u);
        end
      end
    end else begin
      u       = '0;
      u.instr = ins;
      u.last  = 1'b1;
      sb_q.push_back(u);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input logic v, input logic [15:0] ins, input logic rdy,
                       input logic fl, output logic acc);
    uop_t got;
    uop_t exp;
    logic exp_rdy;
    in_valid  = v;
    in_instr  = ins;
    uop_ready = rdy;
    flush     = fl;
    #1;
    check("uop_valid", 32'(uop_valid), 32'(sb_q.size() != 0));
    exp_rdy = !fl && (sb_q.size() == 0 || (rdy && sb_q[0].last));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && in_ready;
    if (uop_valid && rdy) begin
      got = {uop_instr, uop_mode, uop_reg, uop_base, uop_offset, uop_last};
      if (sb_q.size() == 0) begin
        fail_now("uop_unexpected");
      end else begin
        exp = sb_q.pop_front();
        check("uop", 32'(got), 32'(exp));
        handoffs++;
        last_mode = uop_mode;
      end
    end
    if (fl) sb_q.delete();
    else if (acc) push_model(ins);
    @(negedge clk);
  endtask

  task automatic accept_one(input logic [15:0] ins);
    logic acc;
    int   k;
    acc = 1'b0;
    for (k = 0; k < 20 && !acc; k++) cycle(1'b1, ins, 1'b1, 1'b0, acc);
    if (!acc) fail_now("accept_timeout");
  endtask

  task automatic drain();
    logic acc;
    int   k;
    for (k = 0; k < 40 && sb_q.size() != 0; k++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);
    if (sb_q.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic acc;
    logic [15:0] b2b[3];
    int idx;
    int ncyc;

    vecs.push_back('{16'h1254, 1, 2'b00});  // ADD pass-through
    vecs.push_back('{16'h66A1, 3, 2'b01});  // LM R3, {R0,R2,R7}
    vecs.push_back('{16'h72FF, 8, 2'b10});  // SM R1, full list
    vecs.push_back('{16'h6600, 1, 2'b00});  // LM empty list
    vecs.push_back('{16'h7700, 1, 2'b00});  // SM empty list
    vecs.push_back('{16'h7080, 1, 2'b10});  // SM only R0
    vecs.push_back('{16'h6E01, 1, 2'b01});  // LM only R7
    vecs.push_back('{16'h0000, 1, 2'b00});
    vecs.push_back('{16'h8123, 1, 2'b00});
    vecs.push_back('{16'h6A7E, 6, 2'b01});  // LM R5, R1..R6

    // Reset state while resetn is held low.
    #1;
    check("reset_uop", 32'({uop_valid, uop_instr, uop_mode, uop_reg, uop_base, uop_offset, uop_last}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Table-driven vectors, full-rate downstream.
    foreach (vecs[i]) begin
      handoffs = 0;
      accept_one(vecs[i].instr);
      drain();
      check("uop_count", 32'(handoffs), 32'(vecs[i].n_uops));
      check("uop_mode_seen", 32'(last_mode), 32'(vecs[i].mode));
    end

    // Backpressure on the second micro-op of 0x66A1.
    accept_one(16'h66A1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);        // hands off R0
    for (int s = 0; s < 3; s++) begin
      check("bp_hold", 32'({uop_valid, uop_reg, uop_offset}), {25'd0, 1'b1, 3'd2, 3'd1});
      cycle(1'b1, 16'h1254, 1'b0, 1'b0, acc);       // stalled, fetch must wait
      check("bp_no_accept", 32'(acc), 32'd0);
    end
    drain();

    // Flush while 0x72FF presents offset 3, held under backpressure.
    accept_one(16'h72FF);
    for (int s = 0; s < 3; s++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);
    check("flush_at_off3", 32'({uop_valid, uop_offset}), {28'd0, 1'b1, 3'd3});
    cycle(1'b1, 16'h1254, 1'b0, 1'b1, acc);
    check("flush_no_accept", 32'(acc), 32'd0);
    check("flush_valid_low", 32'(uop_valid), 32'd0);
    handoffs = 0;
    accept_one(16'h1254);
    drain();
    check("post_flush_count", 32'(handoffs), 32'd1);

    // Back-to-back LM, SM, ADD with fetch always valid: no bubbles.
    b2b[0] = 16'h66A1;
    b2b[1] = 16'h72FF;
    b2b[2] = 16'h1254;
    idx  = 0;
    ncyc = 0;
    while ((idx < 3 || sb_q.size() != 0) && ncyc < 60) begin
      cycle(idx < 3, (idx < 3) ? b2b[idx] : 16'h0000, 1'b1, 1'b0, acc);
      if (acc) idx++;
      ncyc++;
    end
    check("b2b_cycles", 32'(ncyc), 32'd13);

    // Asynchronous reset in the middle of an SM sequence.
    accept_one(16'h72FF);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, acc);
    #2;
    resetn = 1'b0;
    #1;
    check("midseq_reset_uop", 32'({uop_valid, uop_instr, uop_mode, uop_reg, uop_base, uop_offset, uop_last}), 32'd0);
    check("midseq_reset_in_ready", 32'(in_ready), 32'd0);
    sb_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    handoffs = 0;
    accept_one(16'h6600);
    drain();
    check("post_reset_count", 32'(handoffs), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
Decode-stage controller that sequences IITB-RISC load-multiple (LM) and store-multiple (SM) instructions into single-register micro-ops for the downstream pipeline. All other instructions pass through unchanged as single micro-ops. It sits between the fetch/decode pipeline register and the instruction decode logic. It stalls fetch, through in_ready, while a multi-register sequence is in progress.

Parameters:
OPC_LM, 4'b0110, opcode (instr[15:12]) identifying load-multiple
OPC_SM, 4'b0111, opcode (instr[15:12]) identifying store-multiple

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush (branch/jump redirect)
in_valid  input  1  upstream instruction valid
in_instr  input  16  upstream instruction word
in_ready  output  1  block accepts in_instr this cycle
uop_valid  output  1  micro-op valid
uop_ready  input  1  downstream accepts micro-op this cycle
uop_instr  output  16  originating instruction word
uop_mode  output  2  00 pass-through, 01 LM load, 10 SM store, 11 unused
uop_reg  output  3  register to load/store (LM/SM only, else 0)
uop_base  output  3  base register RA = instr[11:9] (LM/SM only, else 0)
uop_offset  output  3  word offset from RA for this transfer (0..7)
uop_last  output  1  final micro-op of the originating instruction

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; remaining list=0; offset counter=0; all uop_* outputs=0; in_ready=0 while reset is asserted.
- States: IDLE (no sequence pending) and SEQ (LM/SM transfers remaining).
- Output register "advance" condition: adv = !uop_valid || uop_ready. The uop_* outputs hold stable while uop_valid && !uop_ready.
- in_ready = (state==IDLE) && adv && !flush (combinational).
- Accept = in_valid && in_ready. Latency: the first micro-op is presented in the cycle after acceptance.
- Register list mapping: instr[7] -> R0 ... instr[0] -> R7. Transfers are issued in ascending register order, lowest-numbered set register first.
- Accepting a non-LM/SM instruction: emit one uop with mode=00, reg/base/offset=0, last=1. State stays IDLE.
- Accepting LM/SM with list==0: handled as pass-through (mode=00, last=1).
- Accepting LM/SM with list!=0:
  - Emit the first transfer: mode 01 (LM) or 10 (SM), reg=lowest set register, base=instr[11:9], offset=0.
  - Set remaining = list with that bit cleared; set offset counter=1.
  - If remaining==0: last=1 and stay IDLE. Otherwise last=0 and go to SEQ.
- In SEQ, on each adv cycle:
  - Emit the next lowest set register from remaining, with offset=counter, then increment the counter and clear that bit.
  - When the cleared bit was the final one: last=1 and go to IDLE.
  - The latched instruction, base and mode are held for the whole sequence.
- IDLE with adv && !accept: uop_valid goes to 0.
- Offset counter is 3 bits. An 8-bit list produces at most 8 transfers (offsets 0..7), so there is no wrap. The counter resets to 0 on return to IDLE.
- flush=1 (synchronous, highest priority after reset):
  - Next cycle: uop_valid=0, state=IDLE, remaining=0, counter=0.
  - No instruction is accepted in the flush cycle.
  - A micro-op currently held under backpressure is discarded.
- Reset mid-sequence: immediately returns to reset values. The sequence is abandoned, with no partial resume.
- Back-to-back: an LM/SM may be accepted in the same cycle its predecessor's last uop is handed off (adv true, state IDLE), giving zero bubbles.

Test Plan:
- Pass-through: in_instr=0x1254 (ADD), uop_ready=1 -> next cycle uop_valid=1, uop_instr=0x1254, mode=00, last=1; in_ready stays 1.
- LM sequence: in_instr=0x66A1 (LM, RA=R3, list 10100001), uop_ready=1 -> three uops (reg,offset) = (0,0),(2,1),(7,2), base=3, mode=01; last=1 on the third only; in_ready=0 for the cycles in between.
- SM full list: in_instr=0x72FF -> 8 uops, reg 0..7, offset 0..7, mode=10, base=1; in_ready re-asserts in the cycle the last uop is handed off.
- Backpressure: 0x66A1 with uop_ready=0 for 3 cycles on the second uop -> reg=2, offset=1 held stable; the sequence resumes with reg=7 once ready rises.
- Flush mid-sequence: flush=1 while 0x72FF is at offset 3 -> next cycle uop_valid=0, in_ready=1. A following 0x1254 is emitted as pass-through.
- Empty list / reset: 0x6600 yields one mode=00 uop with last=1. Asserting resetn=0 during an SM sequence zeroes all outputs asynchronously.
